ysyx_24100006_axi_xbar: RTL and testbench

YSYX_24100006_AXI_XBAR -- requirements
Module: ysyx_24100006_axi_xbar

---
 rtl/ysyx_24100006_pkg.sv | 18 +
 rtl/ysyx_24100006_xbar_decode.sv | 24 ++
 rtl/ysyx_24100006_axi_xbar.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_ysyx_24100006_axi_xbar.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_pkg.sv
// rtl/ysyx_24100006_pkg.sv - shared crossbar FSM state and AXI response codes
package ysyx_24100006_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    ERR_R,
    ERR_W
  } xbar_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_24100006_xbar_decode.sv
// rtl/ysyx_24100006_xbar_decode.sv - address window decode for the two crossbar slaves
module ysyx_24100006_xbar_decode #(
  parameter logic [31:0] S0_BASE = 32'h8000_0000,
  parameter logic [31:0] S0_SIZE = 32'h0800_0000,
  parameter logic [31:0] S1_BASE = 32'hA000_0000,
  parameter logic [31:0] S1_SIZE = 32'h0000_1000
) (
  input  logic [31:0] addr,
  output logic        hit0,
  output logic        hit1,
  output logic        miss
);

  logic [31:0] off0;
  logic [31:0] off1;

  // Offset compare is one unsigned test for base <= addr < base + size.
  assign off0 = addr - S0_BASE;
  assign off1 = addr - S1_BASE;
  assign hit0 = off0 < S0_SIZE;
  assign hit1 = !hit0 && (off1 < S1_SIZE);
  assign miss = !hit0 && !hit1;

endmodule

// File: rtl/ysyx_24100006_axi_xbar.sv
// rtl/ysyx_24100006_axi_xbar.sv - 1-to-2 AXI-lite crossbar, one outstanding txn; YSYX_24100006_XBAR_TIMEOUT_EN adds slave timeout
module ysyx_24100006_axi_xbar
  import ysyx_24100006_pkg::*;
#(
  parameter logic [31:0] S0_BASE        = 32'h8000_0000,
  parameter logic [31:0] S0_SIZE        = 32'h0800_0000,
  parameter logic [31:0] S1_BASE        = 32'hA000_0000,
  parameter logic [31:0] S1_SIZE        = 32'h0000_1000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_axi_arvalid,
  output logic        m_axi_arready,
  input  logic [31:0] m_axi_araddr,
  output logic        m_axi_rvalid,
  input  logic        m_axi_rready,
  output logic [1:0]  m_axi_rresp,
  output logic [31:0] m_axi_rdata,
  input  logic        m_axi_awvalid,
  output logic        m_axi_awready,
  input  logic [31:0] m_axi_awaddr,
  input  logic        m_axi_wvalid,
  output logic        m_axi_wready,
  input  logic [31:0] m_axi_wdata,
  input  logic [7:0]  m_axi_wstrb,
  output logic        m_axi_bvalid,
  input  logic        m_axi_bready,
  output logic [1:0]  m_axi_bresp,
  output logic        s0_axi_arvalid,
  input  logic        s0_axi_arready,
  output logic [31:0] s0_axi_araddr,
  input  logic        s0_axi_rvalid,
  output logic        s0_axi_rready,
  input  logic [1:0]  s0_axi_rresp,
  input  logic [31:0] s0_axi_rdata,
  output logic        s0_axi_awvalid,
  input  logic        s0_axi_awready,
  output logic [31:0] s0_axi_awaddr,
  output logic        s0_axi_wvalid,
  input  logic        s0_axi_wready,
  output logic [31:0] s0_axi_wdata,
  output logic [7:0]  s0_axi_wstrb,
  input  logic        s0_axi_bvalid,
  output logic        s0_axi_bready,
  input  logic [1:0]  s0_axi_bresp,
  output logic        s1_axi_arvalid,
  input  logic        s1_axi_arready,
  output logic [31:0] s1_axi_araddr,
  input  logic        s1_axi_rvalid,
  output logic        s1_axi_rready,
  input  logic [1:0]  s1_axi_rresp,
  input  logic [31:0] s1_axi_rdata,
  output logic        s1_axi_awvalid,
  input  logic        s1_axi_awready,
  output logic [31:0] s1_axi_awaddr,
  output logic        s1_axi_wvalid,
  input  logic        s1_axi_wready,
  output logic [31:0] s1_axi_wdata,
  output logic [7:0]  s1_axi_wstrb,
  input  logic        s1_axi_bvalid,
  output logic        s1_axi_bready,
  input  logic [1:0]  s1_axi_bresp
);

  xbar_state_e state, state_next;
  logic [31:0] addr_q, wdata_q;
  logic [7:0]  wstrb_q;
  logic        sel_q;
  logic [1:0]  err_resp_q;
  logic        aw_done_q, w_done_q;

  logic rd_hit0, rd_hit1, rd_miss, wr_hit0, wr_hit1, wr_miss;
  logic rd_blocked, wr_blocked, aw_hs, w_hs, pending, timeout;
  logic [1:0] stale;

  logic [1:0]  s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [1:0]  s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic [1:0]  s_rresp [2];
  logic [1:0]  s_bresp [2];
  logic [31:0] s_rdata [2];

  ysyx_24100006_xbar_decode #(
    .S0_BASE(S0_BASE), .S0_SIZE(S0_SIZE), .S1_BASE(S1_BASE), .S1_SIZE(S1_SIZE)
  ) u_rd_decode (
    .addr(m_axi_araddr), .hit0(rd_hit0), .hit1(rd_hit1), .miss(rd_miss)
  );

  ysyx_24100006_xbar_decode #(
    .S0_BASE(S0_BASE), .S0_SIZE(S0_SIZE), .S1_BASE(S1_BASE), .S1_SIZE(S1_SIZE)
  ) u_wr_decode (
    .addr(m_axi_awaddr), .hit0(wr_hit0), .hit1(wr_hit1), .miss(wr_miss)
  );

  logic unused_hits;
  assign unused_hits = rd_hit0 ^ wr_hit0;

  assign s_arready  = {s1_axi_arready, s0_axi_arready};
  assign s_rvalid   = {s1_axi_rvalid, s0_axi_rvalid};
  assign s_awready  = {s1_axi_awready, s0_axi_awready};
  assign s_wready   = {s1_axi_wready, s0_axi_wready};
  assign s_bvalid   = {s1_axi_bvalid, s0_axi_bvalid};
  assign s_rresp[0] = s0_axi_rresp;
  assign s_rresp[1] = s1_axi_rresp;
  assign s_bresp[0] = s0_axi_bresp;
  assign s_bresp[1] = s1_axi_bresp;
  assign s_rdata[0] = s0_axi_rdata;
  assign s_rdata[1] = s1_axi_rdata;

  assign rd_blocked = !rd_miss && stale[rd_hit1];
  assign wr_blocked = !wr_miss && stale[wr_hit1];
  assign aw_hs      = !aw_done_q && s_awready[sel_q];
  assign w_hs       = !w_done_q && s_wready[sel_q];

  // Downstream wait condition that feeds the optional timeout counter.
  always_comb begin
    pending = 1'b0;
    case (state)
      RD_ADDR: pending = !s_arready[sel_q];
      RD_DATA: pending = !s_rvalid[sel_q];
      WR_REQ:  pending = (!aw_done_q && !s_awready[sel_q]) || (!w_done_q && !s_wready[sel_q]);
      WR_RESP: pending = !s_bvalid[sel_q];
      default: pending = 1'b0;
    endcase
  end

  always_comb begin
    state_next    = state;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rresp   = RESP_OKAY;
    m_axi_rdata   = 32'h0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = RESP_OKAY;
    s_arvalid     = 2'b00;
    s_rready      = stale;
    s_awvalid     = 2'b00;
    s_wvalid      = 2'b00;
    s_bready      = stale;
    case (state)
      IDLE: begin
        if (m_axi_arvalid) begin
          if (!rd_blocked) begin
            m_axi_arready = 1'b1;
            state_next    = rd_miss ? ERR_R : RD_ADDR;
          end
        end else if (m_axi_awvalid && m_axi_wvalid && !wr_blocked) begin
          m_axi_awready = 1'b1;
          m_axi_wready  = 1'b1;
          state_next    = wr_miss ? ERR_W : WR_REQ;
        end
      end
      RD_ADDR: begin
        s_arvalid[sel_q] = 1'b1;
        if (s_arready[sel_q]) state_next = RD_DATA;
        else if (timeout)     state_next = ERR_R;
      end
      RD_DATA: begin
        m_axi_rvalid    = s_rvalid[sel_q];
        m_axi_rresp     = s_rresp[sel_q];
        m_axi_rdata     = s_rdata[sel_q];
        s_rready[sel_q] = m_axi_rready;
        if (s_rvalid[sel_q] && m_axi_rready) state_next = IDLE;
        else if (timeout)                    state_next = ERR_R;
      end
      WR_REQ: begin
        s_awvalid[sel_q] = !aw_done_q;
        s_wvalid[sel_q]  = !w_done_q;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_next = WR_RESP;
        else if (timeout)                               state_next = ERR_W;
      end
      WR_RESP: begin
        m_axi_bvalid    = s_bvalid[sel_q];
        m_axi_bresp     = s_bresp[sel_q];
        s_bready[sel_q] = m_axi_bready;
        if (s_bvalid[sel_q] && m_axi_bready) state_next = IDLE;
        else if (timeout)                    state_next = ERR_W;
      end
      ERR_R: begin
        m_axi_rvalid = 1'b1;
        m_axi_rresp  = err_resp_q;
        if (m_axi_rready) state_next = IDLE;
      end
      ERR_W: begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = err_resp_q;
        if (m_axi_bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset is asynchronous, so handshake outputs must drop without waiting for an edge.
    if (!reset) begin
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      s_arvalid     = 2'b00;
      s_rready      = 2'b00;
      s_awvalid     = 2'b00;
      s_wvalid      = 2'b00;
      s_bready      = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 8'h0;
      sel_q      <= 1'b0;
      err_resp_q <= RESP_OKAY;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (m_axi_arready) begin
        addr_q     <= m_axi_araddr;
        sel_q      <= rd_hit1;
        err_resp_q <= RESP_DECERR;
      end else if (m_axi_awready) begin
        addr_q     <= m_axi_awaddr;
        wdata_q    <= m_axi_wdata;
        wstrb_q    <= m_axi_wstrb;
        sel_q      <= wr_hit1;
        err_resp_q <= RESP_DECERR;
      end
      if (timeout) err_resp_q <= RESP_SLVERR;
      if (state == WR_REQ && state_next == WR_REQ) begin
        aw_done_q <= aw_done_q || aw_hs;
        w_done_q  <= w_done_q || w_hs;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
    end
  end

`ifdef YSYX_24100006_XBAR_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic [1:0] stale_q;

  assign timeout = pending && (cnt_q == TIMEOUT_CYCLES);
  assign stale   = stale_q;

  // A timed-out slave owes one late beat; swallow it before reusing the slave.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 8'h0;
      stale_q <= 2'b00;
    end else begin
      if (state_next != state) cnt_q <= 8'h0;
      else if (pending)        cnt_q <= cnt_q + 8'd1;
      if (timeout && !sel_q)                 stale_q[0] <= 1'b1;
      else if (s_rvalid[0] || s_bvalid[0])   stale_q[0] <= 1'b0;
      if (timeout && sel_q)                  stale_q[1] <= 1'b1;
      else if (s_rvalid[1] || s_bvalid[1])   stale_q[1] <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign stale          = 2'b00;
  assign unused_timeout = pending ^ (^TIMEOUT_CYCLES);
`endif

  assign s0_axi_arvalid = s_arvalid[0];
  assign s0_axi_rready  = s_rready[0];
  assign s0_axi_awvalid = s_awvalid[0];
  assign s0_axi_wvalid  = s_wvalid[0];
  assign s0_axi_bready  = s_bready[0];
  assign s0_axi_araddr  = addr_q;
  assign s0_axi_awaddr  = addr_q;
  assign s0_axi_wdata   = wdata_q;
  assign s0_axi_wstrb   = wstrb_q;
  assign s1_axi_arvalid = s_arvalid[1];
  assign s1_axi_rready  = s_rready[1];
  assign s1_axi_awvalid = s_awvalid[1];
  assign s1_axi_wvalid  = s_wvalid[1];
  assign s1_axi_bready  = s_bready[1];
  assign s1_axi_araddr  = addr_q;
  assign s1_axi_awaddr  = addr_q;
  assign s1_axi_wdata   = wdata_q;
  assign s1_axi_wstrb   = wstrb_q;

endmodule

// File: tb/tb_ysyx_24100006_axi_xbar.sv
// tb/tb_ysyx_24100006_axi_xbar.sv - directed self-checking bench for the AXI crossbar
module tb_ysyx_24100006_axi_xbar;

  logic clk, reset;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic [7:0]  m_axi_wstrb;
  logic s0_axi_arvalid, s0_axi_arready, s0_axi_rvalid, s0_axi_rready;
  logic s0_axi_awvalid, s0_axi_awready, s0_axi_wvalid, s0_axi_wready, s0_axi_bvalid, s0_axi_bready;
  logic [31:0] s0_axi_araddr, s0_axi_rdata, s0_axi_awaddr, s0_axi_wdata;
  logic [1:0]  s0_axi_rresp, s0_axi_bresp;
  logic [7:0]  s0_axi_wstrb;
  logic s1_axi_arvalid, s1_axi_arready, s1_axi_rvalid, s1_axi_rready;
  logic s1_axi_awvalid, s1_axi_awready, s1_axi_wvalid, s1_axi_wready, s1_axi_bvalid, s1_axi_bready;
  logic [31:0] s1_axi_araddr, s1_axi_rdata, s1_axi_awaddr, s1_axi_wdata;
  logic [1:0]  s1_axi_rresp, s1_axi_bresp;
  logic [7:0]  s1_axi_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_24100006_axi_xbar dut (
    .clk(clk), .reset(reset),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rresp(m_axi_rresp),
    .m_axi_rdata(m_axi_rdata), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready), .s0_axi_araddr(s0_axi_araddr),
    .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rdata(s0_axi_rdata), .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
    .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready), .s0_axi_bresp(s0_axi_bresp),
    .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready), .s1_axi_araddr(s1_axi_araddr),
    .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rdata(s1_axi_rdata), .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
    .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready), .s1_axi_bresp(s1_axi_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake and activity counters observed at each rising edge.
  int s0_ar_hs = 0, s0_aw_hs = 0, s0_w_hs = 0, s0_act = 0;
  int s1_ar_hs = 0, s1_aw_hs = 0, s1_w_hs = 0, s1_act = 0;
  logic [31:0] s1_awaddr_seen = 32'h0, s1_wdata_seen = 32'h0;
  logic [7:0]  s1_wstrb_seen = 8'h0;

  always @(posedge clk) begin
    if (s0_axi_arvalid && s0_axi_arready) s0_ar_hs <= s0_ar_hs + 1;
    if (s0_axi_awvalid && s0_axi_awready) s0_aw_hs <= s0_aw_hs + 1;
    if (s0_axi_wvalid && s0_axi_wready)   s0_w_hs  <= s0_w_hs + 1;
    if (s1_axi_arvalid && s1_axi_arready) s1_ar_hs <= s1_ar_hs + 1;
    if (s1_axi_awvalid && s1_axi_awready) begin
      s1_aw_hs      <= s1_aw_hs + 1;
      s1_awaddr_seen <= s1_axi_awaddr;
    end
    if (s1_axi_wvalid && s1_axi_wready) begin
      s1_w_hs       <= s1_w_hs + 1;
      s1_wdata_seen <= s1_axi_wdata;
      s1_wstrb_seen <= s1_axi_wstrb;
    end
    if (s0_axi_arvalid | s0_axi_rready | s0_axi_awvalid | s0_axi_wvalid | s0_axi_bready) s0_act <= s0_act + 1;
    if (s1_axi_arvalid | s1_axi_rready | s1_axi_awvalid | s1_axi_wvalid | s1_axi_bready) s1_act <= s1_act + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_ar(input int sl, input logic v);
    if (sl == 0) s0_axi_arready = v; else s1_axi_arready = v;
  endtask

  task automatic set_r(input int sl, input logic v, input logic [31:0] d);
    if (sl == 0) begin s0_axi_rvalid = v; s0_axi_rdata = d; end
    else begin s1_axi_rvalid = v; s1_axi_rdata = d; end
  endtask

  task automatic set_w(input int sl, input logic awr, input logic wr);
    if (sl == 0) begin s0_axi_awready = awr; s0_axi_wready = wr; end
    else begin s1_axi_awready = awr; s1_axi_wready = wr; end
  endtask

  task automatic set_b(input int sl, input logic v);
    if (sl == 0) s0_axi_bvalid = v; else s1_axi_bvalid = v;
  endtask

  // sl < 0: no slave plays; lat < 0: the slave never returns data.
  task automatic read_txn(input string tag, input logic [31:0] a, input int sl, input int lat,
                          input logic [31:0] d, output logic [31:0] rd, output logic [1:0] rr,
                          output int acc_wait, output int rsp_wait);
    m_axi_arvalid = 1'b1;
    m_axi_araddr  = a;
    m_axi_rready  = 1'b1;
    acc_wait = 0;
    rsp_wait = 0;
    settle;
    while (!m_axi_arready && acc_wait < 40) begin step; acc_wait++; settle; end
    check_eq({tag, "_arready"}, m_axi_arready, 1);
    step;
    m_axi_arvalid = 1'b0;
    if (sl >= 0) begin
      set_ar(sl, 1'b1);
      settle;
      check_eq({tag, "_s_arvalid"}, (sl == 0) ? s0_axi_arvalid : s1_axi_arvalid, 1);
      step;
      set_ar(sl, 1'b0);
      if (lat >= 0) begin
        repeat (lat) step;
        settle;
        check_eq({tag, "_no_early_rvalid"}, m_axi_rvalid, 0);
        set_r(sl, 1'b1, d);
      end
    end
    settle;
    while (!m_axi_rvalid && rsp_wait < 400) begin step; rsp_wait++; settle; end
    check_eq({tag, "_rvalid"}, m_axi_rvalid, 1);
    rd = m_axi_rdata;
    rr = m_axi_rresp;
    step;
    if (sl >= 0) set_r(sl, 1'b0, 32'h0);
    m_axi_rready = 1'b0;
  endtask

  task automatic write_txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [7:0] st, input int sl, input int aw_at, input int w_at,
                           output logic [1:0] br, output int acc_wait);
    int wait_b;
    m_axi_awvalid = 1'b1;
    m_axi_wvalid  = 1'b1;
    m_axi_awaddr  = a;
    m_axi_wdata   = d;
    m_axi_wstrb   = st;
    m_axi_bready  = 1'b1;
    acc_wait = 0;
    settle;
    while (!m_axi_awready && acc_wait < 40) begin step; acc_wait++; settle; end
    check_eq({tag, "_awready"}, m_axi_awready, 1);
    check_eq({tag, "_wready"}, m_axi_wready, 1);
    step;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    if (sl >= 0) begin
      for (int c = 0; c <= ((aw_at > w_at) ? aw_at : w_at); c++) begin
        set_w(sl, c >= aw_at, c >= w_at);
        step;
      end
      set_w(sl, 1'b0, 1'b0);
      set_b(sl, 1'b1);
    end
    wait_b = 0;
    settle;
    while (!m_axi_bvalid && wait_b < 40) begin step; wait_b++; settle; end
    check_eq({tag, "_bvalid"}, m_axi_bvalid, 1);
    br = m_axi_bresp;
    step;
    if (sl >= 0) set_b(sl, 1'b0);
    m_axi_bready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr, br;
    int acc, rw, h0, h1, h2, a0, a1;

    reset = 1'b0;
    {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready} = '0;
    m_axi_araddr = 32'h0; m_axi_awaddr = 32'h0; m_axi_wdata = 32'h0; m_axi_wstrb = 8'h0;
    {s0_axi_arready, s0_axi_rvalid, s0_axi_awready, s0_axi_wready, s0_axi_bvalid} = '0;
    {s1_axi_arready, s1_axi_rvalid, s1_axi_awready, s1_axi_wready, s1_axi_bvalid} = '0;
    s0_axi_rresp = 2'b00; s0_axi_bresp = 2'b00; s0_axi_rdata = 32'h0;
    s1_axi_rresp = 2'b00; s1_axi_bresp = 2'b00; s1_axi_rdata = 32'h0;

    // Reset state: requests are ignored and all handshakes stay low.
    step; step;
    m_axi_arvalid = 1'b1; m_axi_awvalid = 1'b1; m_axi_wvalid = 1'b1;
    settle;
    check_eq("rst_arready", m_axi_arready, 0);
    check_eq("rst_awready", m_axi_awready, 0);
    check_eq("rst_rvalid", m_axi_rvalid, 0);
    check_eq("rst_bvalid", m_axi_bvalid, 0);
    check_eq("rst_s0_arvalid", s0_axi_arvalid, 0);
    check_eq("rst_s0_araddr", s0_axi_araddr, 32'h0);
    m_axi_arvalid = 1'b0; m_axi_awvalid = 1'b0; m_axi_wvalid = 1'b0;
    step;
    reset = 1'b1;

    // SRAM read, data three cycles after the address phase.
    a1 = s1_act; h0 = s0_ar_hs;
    read_txn("rd_s0", 32'h8000_0010, 0, 3, 32'hDEAD_BEEF, rd, rr, acc, rw);
    check_eq("rd_s0_rdata", rd, 32'hDEAD_BEEF);
    check_eq("rd_s0_rresp", rr, 2'b00);
    check_eq("rd_s0_accept_wait", acc, 0);
    check_eq("rd_s0_s1_idle", s1_act - a1, 0);
    check_eq("rd_s0_ar_hs", s0_ar_hs - h0, 1);

    // Peripheral write with awready two cycles ahead of wready.
    a0 = s0_act; h1 = s1_aw_hs; h2 = s1_w_hs;
    write_txn("wr_s1", 32'hA000_03F8, 32'h41, 8'h01, 1, 0, 2, br, acc);
    check_eq("wr_s1_bresp", br, 2'b00);
    check_eq("wr_s1_aw_hs", s1_aw_hs - h1, 1);
    check_eq("wr_s1_w_hs", s1_w_hs - h2, 1);
    check_eq("wr_s1_awaddr", s1_awaddr_seen, 32'hA000_03F8);
    check_eq("wr_s1_wdata", s1_wdata_seen, 32'h41);
    check_eq("wr_s1_wstrb", s1_wstrb_seen, 8'h01);
    check_eq("wr_s1_s0_idle", s0_act - a0, 0);

    // Decode misses produce DECERR without touching either slave.
    a0 = s0_act; a1 = s1_act;
    read_txn("rd_miss", 32'h0000_0000, -1, 0, 32'h0, rd, rr, acc, rw);
    check_eq("rd_miss_rresp", rr, 2'b11);
    check_eq("rd_miss_rdata", rd, 32'h0);
    write_txn("wr_miss", 32'h8800_0000, 32'h5, 8'hFF, -1, 0, 0, br, acc);
    check_eq("wr_miss_bresp", br, 2'b11);
    read_txn("rd_s1_end", 32'hA000_1000, -1, 0, 32'h0, rd, rr, acc, rw);
    check_eq("rd_s1_end_rresp", rr, 2'b11);
    check_eq("miss_s0_idle", s0_act - a0, 0);
    check_eq("miss_s1_idle", s1_act - a1, 0);

    // Window edges decode into the right slave.
    read_txn("rd_s1_top", 32'hA000_0FFC, 1, 0, 32'h1357_9BDF, rd, rr, acc, rw);
    check_eq("rd_s1_top_rdata", rd, 32'h1357_9BDF);
    read_txn("rd_s0_top", 32'h87FF_FFFC, 0, 1, 32'h2468_ACE0, rd, rr, acc, rw);
    check_eq("rd_s0_top_rdata", rd, 32'h2468_ACE0);

    // Simultaneous read and write: read first, write right after.
    m_axi_awvalid = 1'b1; m_axi_wvalid = 1'b1; m_axi_awaddr = 32'h8000_0000;
    m_axi_wdata = 32'hCAFE_F00D; m_axi_wstrb = 8'hFF;
    m_axi_arvalid = 1'b1; m_axi_araddr = 32'h8000_0000;
    settle;
    check_eq("arb_arready", m_axi_arready, 1);
    check_eq("arb_awready", m_axi_awready, 0);
    h1 = s0_aw_hs;
    read_txn("arb_rd", 32'h8000_0000, 0, 1, 32'h0BAD_CAFE, rd, rr, acc, rw);
    check_eq("arb_rd_rdata", rd, 32'h0BAD_CAFE);
    check_eq("arb_no_early_aw", s0_aw_hs - h1, 0);
    write_txn("arb_wr", 32'h8000_0000, 32'hCAFE_F00D, 8'hFF, 0, 0, 0, br, acc);
    check_eq("arb_wr_accept_wait", acc, 0);
    check_eq("arb_wr_bresp", br, 2'b00);
    check_eq("arb_wr_aw_hs", s0_aw_hs - h1, 1);

    // Reset while a read sits in RD_DATA.
    m_axi_arvalid = 1'b1; m_axi_araddr = 32'h8000_0040; m_axi_rready = 1'b1;
    s0_axi_arready = 1'b1;
    settle;
    check_eq("mid_rst_arready", m_axi_arready, 1);
    step;
    m_axi_arvalid = 1'b0;
    step;
    s0_axi_arready = 1'b0;
    s0_axi_rvalid = 1'b1; s0_axi_rdata = 32'h7777_0000;
    settle;
    check_eq("mid_rst_pre_rvalid", m_axi_rvalid, 1);
    reset = 1'b0;
    m_axi_arvalid = 1'b1;
    settle;
    check_eq("mid_rst_rvalid", m_axi_rvalid, 0);
    check_eq("mid_rst_s0_rready", s0_axi_rready, 0);
    check_eq("mid_rst_arready_low", m_axi_arready, 0);
    s0_axi_rvalid = 1'b0; m_axi_arvalid = 1'b0; m_axi_rready = 1'b0;
    step; step;
    reset = 1'b1;
    read_txn("post_rst", 32'hA000_0010, 1, 0, 32'h1234_5678, rd, rr, acc, rw);
    check_eq("post_rst_accept_wait", acc, 0);
    check_eq("post_rst_rdata", rd, 32'h1234_5678);
    check_eq("post_rst_rresp", rr, 2'b00);

`ifdef YSYX_24100006_XBAR_TIMEOUT_EN
    // Silent SRAM: SLVERR after the wait limit, then the late beat is swallowed.
    read_txn("to_rd", 32'h8000_0020, 0, -1, 32'h0, rd, rr, acc, rw);
    check_eq("to_rresp", rr, 2'b10);
    check_eq("to_wait_range", (rw >= 250 && rw <= 260), 1);
    s0_axi_rvalid = 1'b1; s0_axi_rdata = 32'h5555_5555;
    settle;
    check_eq("to_absorb_rready", s0_axi_rready, 1);
    check_eq("to_absorb_no_rvalid", m_axi_rvalid, 0);
    step;
    s0_axi_rvalid = 1'b0;
    settle;
    check_eq("to_stale_cleared", s0_axi_rready, 0);
    read_txn("to_after", 32'h8000_0024, 0, 0, 32'hA5A5_5A5A, rd, rr, acc, rw);
    check_eq("to_after_rdata", rd, 32'hA5A5_5A5A);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
